// File: rtl/ctrl_pkg.sv
// Shared definitions for the control pipeline: control-word layout, forwarding
// encodings and the per-stage control structs.
package ctrl_pkg;

    localparam int CB_MEM_TO_REG = 8;
    localparam int CB_REG_WRITE  = 7;
    localparam int CB_BRANCH     = 6;
    localparam int CB_MEM_READ   = 5;
    localparam int CB_MEM_WRITE  = 4;
    localparam int CB_REG_DST    = 3;
    localparam int CB_ALU_SRC    = 2;
    localparam int CB_ALU_OP     = 0;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
    } ctrl_t;

    // Fields that survive past EX and past MEM respectively.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
        logic branch;
        logic mem_read;
        logic mem_write;
    } exmem_ctrl_t;

    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } memwb_ctrl_t;

    function automatic logic [1:0] fwd_pick(input logic exmem_hit, input logic memwb_hit);
        if (exmem_hit)      return FWD_EXMEM;
        else if (memwb_hit) return FWD_MEMWB;
        else                return FWD_RF;
    endfunction

endpackage

// File: rtl/ctrl_hazard_unit.sv
// Combinational hazard logic: load-use detect, branch flush, operand forwarding
// and the PC / IF-ID write enables.
module ctrl_hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              i_stall_ext,
    input  logic              i_id_valid,
    input  logic [REG_AW-1:0] i_id_rs,
    input  logic [REG_AW-1:0] i_id_rt,
    input  logic              i_idex_mem_read,
    input  logic [REG_AW-1:0] i_idex_rs,
    input  logic [REG_AW-1:0] i_idex_rt,
    input  logic              i_exmem_branch,
    input  logic              i_exmem_reg_write,
    input  logic [REG_AW-1:0] i_exmem_dest,
    input  logic              i_memwb_reg_write,
    input  logic [REG_AW-1:0] i_memwb_dest,
    input  logic              i_branch_taken,
    output logic              o_lu,
    output logic              o_flush,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_ifid_flush,
    output logic              o_pc_src
);

    logic w_exmem_fwd;
    logic w_memwb_fwd;

    assign o_lu = i_idex_mem_read && (i_idex_rt != '0) && i_id_valid &&
                  ((i_idex_rt == i_id_rs) || (i_idex_rt == i_id_rt));

    assign o_flush = i_exmem_branch && i_branch_taken;

    // Register 0 is hard-wired, so a write to it never forwards.
    assign w_exmem_fwd = i_exmem_reg_write && (i_exmem_dest != '0);
    assign w_memwb_fwd = i_memwb_reg_write && (i_memwb_dest != '0);

    assign o_fwd_a = fwd_pick(w_exmem_fwd && (i_exmem_dest == i_idex_rs),
                              w_memwb_fwd && (i_memwb_dest == i_idex_rs));
    assign o_fwd_b = fwd_pick(w_exmem_fwd && (i_exmem_dest == i_idex_rt),
                              w_memwb_fwd && (i_memwb_dest == i_idex_rt));

    // A flush redirects fetch, so it releases any load-use hold.
    assign o_pc_write   = !i_stall_ext && (o_flush || !o_lu);
    assign o_ifid_write = !i_stall_ext && (o_flush || !o_lu);
    assign o_ifid_flush = !i_stall_ext && o_flush;
    assign o_pc_src     = !i_stall_ext && o_flush;

endmodule

// File: rtl/ctrl_pipeline.sv
// Control-word pipeline (ID/EX, EX/MEM, MEM/WB) with destination tags, plus
// the hazard unit that drives stall, flush and forwarding.
module ctrl_pipeline
    import ctrl_pkg::*;
#(
    parameter int CTRL_W = 9,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              stall_ext,
    input  logic              mem_branch_taken,
    output logic              ex_reg_dst,
    output logic              ex_alu_src,
    output logic [1:0]        ex_alu_op,
    output logic              mem_branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [REG_AW-1:0] wb_dest,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              pc_src
);

    ctrl_t             r_idex_ctrl;
    logic [REG_AW-1:0] r_idex_rs;
    logic [REG_AW-1:0] r_idex_rt;
    logic [REG_AW-1:0] r_idex_rd;
    exmem_ctrl_t       r_exmem_ctrl;
    logic [REG_AW-1:0] r_exmem_dest;
    memwb_ctrl_t       r_memwb_ctrl;
    logic [REG_AW-1:0] r_memwb_dest;

    ctrl_t             w_id_ctrl;
    logic [REG_AW-1:0] w_ex_dest;
    logic              w_lu;
    logic              w_flush;

    assign w_id_ctrl = ctrl_t'(id_ctrl);
    assign w_ex_dest = r_idex_ctrl.reg_dst ? r_idex_rd : r_idex_rt;

    ctrl_hazard_unit #(.REG_AW(REG_AW)) u_hazard (
        .i_stall_ext       (stall_ext),
        .i_id_valid        (id_valid),
        .i_id_rs           (id_rs),
        .i_id_rt           (id_rt),
        .i_idex_mem_read   (r_idex_ctrl.mem_read),
        .i_idex_rs         (r_idex_rs),
        .i_idex_rt         (r_idex_rt),
        .i_exmem_branch    (r_exmem_ctrl.branch),
        .i_exmem_reg_write (r_exmem_ctrl.reg_write),
        .i_exmem_dest      (r_exmem_dest),
        .i_memwb_reg_write (r_memwb_ctrl.reg_write),
        .i_memwb_dest      (r_memwb_dest),
        .i_branch_taken    (mem_branch_taken),
        .o_lu              (w_lu),
        .o_flush           (w_flush),
        .o_fwd_a           (fwd_a),
        .o_fwd_b           (fwd_b),
        .o_pc_write        (pc_write),
        .o_ifid_write      (ifid_write),
        .o_ifid_flush      (ifid_flush),
        .o_pc_src          (pc_src)
    );

    // Bubbles also clear their register tags so they can never match anything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idex_ctrl  <= '0;
            r_idex_rs    <= '0;
            r_idex_rt    <= '0;
            r_idex_rd    <= '0;
            r_exmem_ctrl <= '0;
            r_exmem_dest <= '0;
            r_memwb_ctrl <= '0;
            r_memwb_dest <= '0;
        end else if (!stall_ext) begin
            if (w_flush || w_lu || !id_valid) begin
                r_idex_ctrl <= '0;
                r_idex_rs   <= '0;
                r_idex_rt   <= '0;
                r_idex_rd   <= '0;
            end else begin
                r_idex_ctrl <= w_id_ctrl;
                r_idex_rs   <= id_rs;
                r_idex_rt   <= id_rt;
                r_idex_rd   <= id_rd;
            end

            if (w_flush) begin
                r_exmem_ctrl <= '0;
                r_exmem_dest <= '0;
            end else begin
                r_exmem_ctrl <= '{mem_to_reg: r_idex_ctrl.mem_to_reg,
                                  reg_write:  r_idex_ctrl.reg_write,
                                  branch:     r_idex_ctrl.branch,
                                  mem_read:   r_idex_ctrl.mem_read,
                                  mem_write:  r_idex_ctrl.mem_write};
                r_exmem_dest <= w_ex_dest;
            end

            r_memwb_ctrl <= '{mem_to_reg: r_exmem_ctrl.mem_to_reg,
                              reg_write:  r_exmem_ctrl.reg_write};
            r_memwb_dest <= r_exmem_dest;
        end
    end

    assign ex_reg_dst    = r_idex_ctrl.reg_dst;
    assign ex_alu_src    = r_idex_ctrl.alu_src;
    assign ex_alu_op     = r_idex_ctrl.alu_op;
    assign mem_branch    = r_exmem_ctrl.branch;
    assign mem_read      = r_exmem_ctrl.mem_read;
    assign mem_write     = r_exmem_ctrl.mem_write;
    assign wb_reg_write  = r_memwb_ctrl.reg_write;
    assign wb_mem_to_reg = r_memwb_ctrl.mem_to_reg;
    assign wb_dest       = r_memwb_dest;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: instruction-level pipeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_ctrl_pipeline;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [8:0] id_ctrl = '0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       stall_ext = 1'b0;
    logic       mem_branch_taken = 1'b0;

    logic       ex_reg_dst, ex_alu_src, mem_branch, mem_read, mem_write;
    logic       wb_reg_write, wb_mem_to_reg, pc_write, ifid_write, ifid_flush, pc_src;
    logic [1:0] ex_alu_op, fwd_a, fwd_b;
    logic [4:0] wb_dest;

    int n_cmp = 0;
    int n_err = 0;

    ctrl_pipeline #(.CTRL_W(9), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .stall_ext(stall_ext),
        .mem_branch_taken(mem_branch_taken), .ex_reg_dst(ex_reg_dst),
        .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .mem_branch(mem_branch),
        .mem_read(mem_read), .mem_write(mem_write), .wb_reg_write(wb_reg_write),
        .wb_mem_to_reg(wb_mem_to_reg), .wb_dest(wb_dest), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush), .pc_src(pc_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one whole instruction per stage slot
    typedef struct packed {
        logic [8:0] c;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       real_i;
    } inst_t;

    localparam inst_t BUB = '0;
    inst_t m_ex = '0, m_mem = '0, m_wb = '0;

    function automatic logic [4:0] m_dest(input inst_t x);
        return x.c[3] ? x.rd : x.rt;
    endfunction

    function automatic logic m_writes(input inst_t x, input logic [4:0] r);
        return x.c[7] && (m_dest(x) != 5'd0) && (m_dest(x) == r);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] r);
        if (m_writes(m_mem, r)) return 2'b10;
        if (m_writes(m_wb, r))  return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        return m_ex.c[5] && (m_ex.rt != 5'd0) && id_valid &&
               ((m_ex.rt == id_rs) || (m_ex.rt == id_rt));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ex = BUB; m_mem = BUB; m_wb = BUB;
        end else if (!stall_ext) begin : adv
            logic fl, lu;
            fl = m_mem.c[6] && mem_branch_taken;
            lu = m_lu();
            m_wb  = m_mem;
            m_mem = fl ? BUB : m_ex;
            if (fl || lu || !id_valid) m_ex = BUB;
            else m_ex = '{c: id_ctrl, rs: id_rs, rt: id_rt, rd: id_rd, real_i: 1'b1};
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin : cmp
            logic fl, lu;
            fl = m_mem.c[6] && mem_branch_taken;
            lu = m_lu();
            chk("ex_reg_dst",    ex_reg_dst,    m_ex.c[3]);
            chk("ex_alu_src",    ex_alu_src,    m_ex.c[2]);
            chk("ex_alu_op",     ex_alu_op,     m_ex.c[1:0]);
            chk("mem_branch",    mem_branch,    m_mem.c[6]);
            chk("mem_read",      mem_read,      m_mem.c[5]);
            chk("mem_write",     mem_write,     m_mem.c[4]);
            chk("wb_reg_write",  wb_reg_write,  m_wb.c[7]);
            chk("wb_mem_to_reg", wb_mem_to_reg, m_wb.c[8]);
            if (m_wb.c[7]) chk("wb_dest", wb_dest, m_dest(m_wb));
            if (m_ex.real_i) begin
                chk("fwd_a", fwd_a, m_fwd(m_ex.rs));
                chk("fwd_b", fwd_b, m_fwd(m_ex.rt));
            end
            chk("pc_src",     pc_src,     fl && !stall_ext);
            chk("ifid_flush", ifid_flush, fl && !stall_ext);
            chk("pc_write",   pc_write,   !stall_ext && (fl || !lu));
            chk("ifid_write", ifid_write, !stall_ext && (fl || !lu));
        end
    end

    // ---------------- stimulus
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [8:0] c, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_ctrl = c; id_rs = rs; id_rt = rt; id_rd = rd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 9'h000, 5'd0, 5'd0, 5'd0);
        repeat (n) cyc();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ex"},   {ex_reg_dst, ex_alu_src, ex_alu_op}, 32'h0);
        chk({tag, "_mem"},  {mem_branch, mem_read, mem_write}, 32'h0);
        chk({tag, "_wb"},   {wb_reg_write, wb_mem_to_reg, wb_dest}, 32'h0);
        chk({tag, "_fwd"},  {fwd_a, fwd_b}, 32'h0);
        chk({tag, "_pcw"},  {pc_write, ifid_write}, 32'h3);
        chk({tag, "_fl"},   {ifid_flush, pc_src}, 32'h0);
    endtask

    localparam logic [8:0] LW  = 9'h1A4;
    localparam logic [8:0] RT  = 9'h08A;
    localparam logic [8:0] BEQ = 9'h041;
    localparam logic [8:0] SW  = 9'h014;

    initial begin
        #3;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Straight flow
        drive(1'b1, LW, 5'd1, 5'd2, 5'd0); cyc();
        drive(1'b1, RT, 5'd3, 5'd4, 5'd6); #1;
        chk("flow_ex_alu_src", ex_alu_src, 1'b1);
        cyc(); drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); #1;
        chk("flow_mem_read", mem_read, 1'b1);
        cyc();
        chk("flow_wb", {wb_mem_to_reg, wb_reg_write, wb_dest}, {2'b11, 5'd2});
        idle(3);

        // Load-use
        drive(1'b1, LW, 5'd1, 5'd5, 5'd0); cyc();
        drive(1'b1, RT, 5'd5, 5'd7, 5'd8); #1;
        chk("lu_hold", {pc_write, ifid_write}, 2'b00);
        cyc();
        chk("lu_bubble_ex", {ex_reg_dst, ex_alu_src, ex_alu_op}, 4'h0);
        chk("lu_release", {pc_write, ifid_write}, 2'b11);
        cyc(); drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); #1;
        chk("lu_fwd_a", fwd_a, 2'b01);
        idle(3);

        // EX forwarding, then the same with register 0
        drive(1'b1, RT, 5'd1, 5'd2, 5'd3); cyc();
        drive(1'b1, RT, 5'd4, 5'd3, 5'd9); cyc();
        drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); #1;
        chk("exfwd_b", fwd_b, 2'b10);
        idle(3);
        drive(1'b1, RT, 5'd1, 5'd2, 5'd0); cyc();
        drive(1'b1, RT, 5'd4, 5'd0, 5'd9); cyc();
        drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); #1;
        chk("exfwd_r0", fwd_b, 2'b00);
        idle(3);

        // Branch flush overriding a simultaneous load-use
        drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0); cyc();
        drive(1'b1, LW, 5'd3, 5'd5, 5'd0); cyc();
        drive(1'b1, RT, 5'd5, 5'd6, 5'd7); mem_branch_taken = 1'b1; #1;
        chk("br_flush", {pc_src, ifid_flush}, 2'b11);
        chk("br_over_lu", {pc_write, ifid_write}, 2'b11);
        cyc(); drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); mem_branch_taken = 1'b0; #1;
        chk("br_ex_zero", {ex_reg_dst, ex_alu_src, ex_alu_op}, 4'h0);
        chk("br_mem_zero", {mem_branch, mem_read, mem_write}, 3'h0);
        idle(3);

        // External stall with a taken branch waiting in MEM
        drive(1'b1, BEQ, 5'd1, 5'd2, 5'd0); cyc();
        drive(1'b1, RT, 5'd1, 5'd2, 5'd3); cyc();
        drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0);
        stall_ext = 1'b1; mem_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_nosrc", {pc_src, ifid_flush, pc_write, ifid_write}, 4'h0);
            chk("stall_hold", {mem_branch, ex_alu_op, ex_reg_dst}, {1'b1, 2'b10, 1'b1});
            @(posedge clk); #1;
        end
        stall_ext = 1'b0; #1;
        chk("stall_release_flush", {pc_src, ifid_flush}, 2'b11);
        cyc(); mem_branch_taken = 1'b0; #1;
        chk("stall_flushed", {mem_branch, ex_alu_op}, 3'h0);
        idle(3);

        // Reset mid-stream with a store in MEM
        drive(1'b1, SW, 5'd1, 5'd2, 5'd0); cyc();
        drive(1'b1, RT, 5'd3, 5'd4, 5'd5); cyc();
        drive(1'b0, 9'h0, 5'd0, 5'd0, 5'd0); #1;
        chk("rst_sw_in_mem", mem_write, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mem_write", mem_write, 1'b0);
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Randomized traffic; small register range keeps hazards frequent
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 9) < 8, 9'($urandom_range(0, 511)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            stall_ext        = ($urandom_range(0, 9) == 0);
            mem_branch_taken = $urandom_range(0, 1) == 1;
            cyc();
        end
        stall_ext = 1'b0; mem_branch_taken = 1'b0;
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
